// File: rtl/ysyx_22040237_exu_mc.sv
// -----------------------------------------------------------------------------
// ysyx_22040237_exu_mc -- multi-cycle execute unit
//
// Takes one decoded op per valid/ready handshake and returns a registered
// result together with the jump target (in_j1 + in_j2). Integer ALU ops finish
// one cycle after accept. MUL/DIV/DIVU/REM/REMU run on a shared iterative
// datapath and take XLEN+1 cycles: the accept cycle plus XLEN iterations, with
// the sign fix-up folded into the last iteration. ebreak/illegal are returned
// as flags; this block never traps.
//
// Build option: YSYX_22040237_EXU_MULDIV_EN
//   defined   -> iterative mul/div datapath and BUSY state are built
//   undefined -> ops 10-14 behave like the reserved op (rd=0, invalid=1, 1 cycle)
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   flush               drop the in-flight op or held result (no accept that cycle)
//   in_valid/in_ready   op handshake
//   in_op               0 ADD 1 SUB 2 AND 3 OR 4 XOR 5 SLL 6 SRL 7 SRA 8 SLT 9 SLTU
//                       10 MUL 11 DIV 12 DIVU 13 REM 14 REMU 15 reserved
//   in_op1/in_op2       ALU operands
//   in_j1/in_j2         jump address operands
//   in_ebreak           decoded ebreak, carried to out_ebreak
//   in_invalid          decoded illegal instruction
//   out_valid/out_ready result handshake; outputs held while out_valid & !out_ready
//   out_rd_data         result
//   out_jump_addr       in_j1 + in_j2 captured at accept
//   out_ebreak          registered in_ebreak
//   out_invalid         registered in_invalid or reserved/unsupported op
// -----------------------------------------------------------------------------
module ysyx_22040237_exu_mc #(
   parameter int XLEN = 64,
   parameter int OPW  = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [OPW-1:0]  in_op,
   input  logic [XLEN-1:0] in_op1,
   input  logic [XLEN-1:0] in_op2,
   input  logic [XLEN-1:0] in_j1,
   input  logic [XLEN-1:0] in_j2,
   input  logic            in_ebreak,
   input  logic            in_invalid,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_rd_data,
   output logic [XLEN-1:0] out_jump_addr,
   output logic            out_ebreak,
   output logic            out_invalid
);

   localparam int SHW = $clog2(XLEN);

   localparam logic [OPW-1:0] OP_ADD  = OPW'(0);
   localparam logic [OPW-1:0] OP_SUB  = OPW'(1);
   localparam logic [OPW-1:0] OP_AND  = OPW'(2);
   localparam logic [OPW-1:0] OP_OR   = OPW'(3);
   localparam logic [OPW-1:0] OP_XOR  = OPW'(4);
   localparam logic [OPW-1:0] OP_SLL  = OPW'(5);
   localparam logic [OPW-1:0] OP_SRL  = OPW'(6);
   localparam logic [OPW-1:0] OP_SRA  = OPW'(7);
   localparam logic [OPW-1:0] OP_SLT  = OPW'(8);
   localparam logic [OPW-1:0] OP_SLTU = OPW'(9);
   localparam logic [OPW-1:0] OP_MUL  = OPW'(10);
   localparam logic [OPW-1:0] OP_DIV  = OPW'(11);
   localparam logic [OPW-1:0] OP_DIVU = OPW'(12);
   localparam logic [OPW-1:0] OP_REM  = OPW'(13);
   localparam logic [OPW-1:0] OP_REMU = OPW'(14);
   localparam logic [OPW-1:0] OP_RSVD = OPW'(15);

`ifdef YSYX_22040237_EXU_MULDIV_EN
   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;
`else
   typedef enum logic [1:0] {S_IDLE, S_DONE} state_e;
`endif

   state_e          state_q, state_d;
   logic [XLEN-1:0] rd_q, rd_d;
   logic [XLEN-1:0] jump_q, jump_d;
   logic            ebreak_q, ebreak_d;
   logic            invalid_q, invalid_d;

   logic            accept;
   logic            op_md;
   logic            op_bad;
   logic [SHW-1:0]  shamt;
   logic [XLEN-1:0] alu_res;

   // Handshake -------------------------------------------------------------
   assign in_ready = !rst && !flush &&
                     ((state_q == S_IDLE) || ((state_q == S_DONE) && out_ready));
   assign accept   = in_valid && in_ready;
   assign op_md    = (in_op >= OP_MUL) && (in_op <= OP_REMU);

`ifdef YSYX_22040237_EXU_MULDIV_EN
   assign op_bad = in_invalid || (in_op == OP_RSVD);
`else
   assign op_bad = in_invalid || (in_op == OP_RSVD) || op_md;
`endif

   // Single-cycle ALU ------------------------------------------------------
   assign shamt = in_op2[SHW-1:0];

   always_comb begin
      alu_res = '0;
      case (in_op)
         OP_ADD:  alu_res = in_op1 + in_op2;
         OP_SUB:  alu_res = in_op1 - in_op2;
         OP_AND:  alu_res = in_op1 & in_op2;
         OP_OR:   alu_res = in_op1 | in_op2;
         OP_XOR:  alu_res = in_op1 ^ in_op2;
         OP_SLL:  alu_res = in_op1 << shamt;
         OP_SRL:  alu_res = in_op1 >> shamt;
         OP_SRA:  alu_res = $signed(in_op1) >>> shamt;
         OP_SLT:  alu_res = XLEN'($signed(in_op1) < $signed(in_op2));
         OP_SLTU: alu_res = XLEN'(in_op1 < in_op2);
         default: alu_res = '0;
      endcase
   end

`ifdef YSYX_22040237_EXU_MULDIV_EN
   // Iterative MUL / DIV ---------------------------------------------------
   // MUL: acc accumulates, a holds the shifting multiplicand, b the multiplier.
   // DIV: acc is the partial remainder, a shifts the dividend out and the
   //      quotient in, b is the divisor magnitude.
   logic            md_start, md_last;
   logic [XLEN-1:0] md_result;
   logic [XLEN-1:0] acc_q, acc_d, a_q, a_d, b_q, b_d;
   logic [SHW-1:0]  cnt_q, cnt_d;
   logic [OPW-1:0]  mop_q, mop_d;
   logic            qneg_q, qneg_d, rneg_q, rneg_d;
   logic            op_signed, a_neg, b_neg, ge;
   logic [XLEN-1:0] a_mag, b_mag, r_lo, diff;

   assign md_start = accept && op_md && !op_bad;
   assign md_last  = (cnt_q == SHW'(XLEN - 1));

   always_comb begin
      op_signed = (in_op == OP_DIV) || (in_op == OP_REM);
      a_neg     = op_signed && in_op1[XLEN-1];
      b_neg     = op_signed && in_op2[XLEN-1];
      a_mag     = a_neg ? -in_op1 : in_op1;
      b_mag     = b_neg ? -in_op2 : in_op2;

      // Shifted remainder is XLEN+1 bits wide; its top bit is acc_q[XLEN-1],
      // and when set the value already exceeds any divisor. The low XLEN bits
      // of the difference are exact because the true difference is < divisor.
      r_lo = {acc_q[XLEN-2:0], a_q[XLEN-1]};
      ge   = acc_q[XLEN-1] || (r_lo >= b_q);
      diff = r_lo - b_q;

      acc_d     = acc_q;
      a_d       = a_q;
      b_d       = b_q;
      cnt_d     = cnt_q;
      mop_d     = mop_q;
      qneg_d    = qneg_q;
      rneg_d    = rneg_q;
      md_result = '0;

      if (md_start) begin
         mop_d  = in_op;
         cnt_d  = '0;
         acc_d  = '0;
         a_d    = (in_op == OP_MUL) ? in_op1 : a_mag;
         b_d    = (in_op == OP_MUL) ? in_op2 : b_mag;
         // Divide by zero keeps the all-ones quotient, so never negate it.
         qneg_d = (a_neg ^ b_neg) && (in_op2 != '0);
         rneg_d = a_neg;
      end else if (state_q == S_BUSY) begin
         cnt_d = cnt_q + SHW'(1);
         if (mop_q == OP_MUL) begin
            if (b_q[0]) acc_d = acc_q + a_q;
            a_d = a_q << 1;
            b_d = b_q >> 1;
         end else begin
            acc_d = ge ? diff : r_lo;
            a_d   = {a_q[XLEN-2:0], ge};
         end
      end

      // Sign fix-up applied to the next-state values so the final iteration
      // and the fix-up share one cycle.
      case (mop_q)
         OP_MUL:          md_result = acc_d;
         OP_DIV, OP_DIVU: md_result = qneg_q ? -a_d : a_d;
         default:         md_result = rneg_q ? -acc_d : acc_d;
      endcase

      if (flush) cnt_d = '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q  <= '0;
         a_q    <= '0;
         b_q    <= '0;
         cnt_q  <= '0;
         mop_q  <= '0;
         qneg_q <= 1'b0;
         rneg_q <= 1'b0;
      end else begin
         acc_q  <= acc_d;
         a_q    <= a_d;
         b_q    <= b_d;
         cnt_q  <= cnt_d;
         mop_q  <= mop_d;
         qneg_q <= qneg_d;
         rneg_q <= rneg_d;
      end
   end
`endif

   // Control FSM next state / result capture --------------------------------
   always_comb begin
      // NOTE: every signal gets its hold value first, so no path through the
      // branches below leaves one unassigned and infers a latch.
      state_d   = state_q;
      rd_d      = rd_q;
      jump_d    = jump_q;
      ebreak_d  = ebreak_q;
      invalid_d = invalid_q;

      if (accept) begin
         jump_d    = in_j1 + in_j2;
         ebreak_d  = in_ebreak;
         invalid_d = op_bad;
         rd_d      = op_bad ? '0 : alu_res;
         state_d   = S_DONE;
`ifdef YSYX_22040237_EXU_MULDIV_EN
         if (md_start) state_d = S_BUSY;
`endif
      end else begin
         case (state_q)
`ifdef YSYX_22040237_EXU_MULDIV_EN
            S_BUSY: begin
               if (md_last) begin
                  state_d = S_DONE;
                  rd_d    = md_result;
               end
            end
`endif
            S_DONE:  if (out_ready) state_d = S_IDLE;
            default: state_d = state_q;
         endcase
      end

      // accept is already blocked by flush through in_ready.
      if (flush) state_d = S_IDLE;
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge value regardless of statement order.
      if (rst) begin
         state_q   <= S_IDLE;
         rd_q      <= '0;
         jump_q    <= '0;
         ebreak_q  <= 1'b0;
         invalid_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         rd_q      <= rd_d;
         jump_q    <= jump_d;
         ebreak_q  <= ebreak_d;
         invalid_q <= invalid_d;
      end
   end

   assign out_valid     = (state_q == S_DONE);
   assign out_rd_data   = rd_q;
   assign out_jump_addr = jump_q;
   assign out_ebreak    = ebreak_q;
   assign out_invalid   = invalid_q;

endmodule

// File: tb/tb_ysyx_22040237_exu_mc.sv
// -----------------------------------------------------------------------------
// Bench for ysyx_22040237_exu_mc (XLEN=64). Expected results come from a
// plain-arithmetic reference function; latency is counted in clock edges from
// the accept edge to the first sample showing out_valid. Works with or without
// YSYX_22040237_EXU_MULDIV_EN defined.
// -----------------------------------------------------------------------------
module tb_ysyx_22040237_exu_mc;

   localparam int          XLEN = 64;
   localparam logic [63:0] MIN  = 64'h8000_0000_0000_0000;
   localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
`ifdef YSYX_22040237_EXU_MULDIV_EN
   localparam bit MD_EN = 1'b1;
`else
   localparam bit MD_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic        in_ebreak = 1'b0;
   logic        in_invalid = 1'b0;
   logic [3:0]  in_op = 4'd0;
   logic [63:0] in_op1 = '0, in_op2 = '0, in_j1 = '0, in_j2 = '0;
   logic        in_ready, out_valid, out_ebreak, out_invalid;
   logic [63:0] out_rd_data, out_jump_addr;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   ysyx_22040237_exu_mc #(.XLEN(XLEN), .OPW(4)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_op1(in_op1), .in_op2(in_op2), .in_j1(in_j1), .in_j2(in_j2),
      .in_ebreak(in_ebreak), .in_invalid(in_invalid),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_rd_data(out_rd_data), .out_jump_addr(out_jump_addr),
      .out_ebreak(out_ebreak), .out_invalid(out_invalid)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference model ---------------------------------------------------------
   function automatic bit ref_inv(input logic [3:0] op, input logic inv);
      return inv || (op == 4'd15) || (!MD_EN && op >= 4'd10);
   endfunction

   function automatic int ref_lat(input logic [3:0] op, input logic inv);
      return (op >= 4'd10 && op <= 4'd14 && !ref_inv(op, inv)) ? XLEN + 1 : 1;
   endfunction

   function automatic logic [63:0] ref_rd(input logic [3:0] op, input logic [63:0] a,
                                          input logic [63:0] b, input logic inv);
      longint sa, sb;
      logic [5:0] sh;
      sa = a;
      sb = b;
      sh = b[5:0];
      if (ref_inv(op, inv)) return 64'd0;
      case (op)
         4'd0:  return a + b;
         4'd1:  return a - b;
         4'd2:  return a & b;
         4'd3:  return a | b;
         4'd4:  return a ^ b;
         4'd5:  return a << sh;
         4'd6:  return a >> sh;
         4'd7:  return sa >>> sh;
         4'd8:  return (sa < sb) ? 64'd1 : 64'd0;
         4'd9:  return (a < b) ? 64'd1 : 64'd0;
         4'd10: return a * b;
         4'd11: begin
            if (b == 0) return ONES;
            if (a == MIN && b == ONES) return a;
            return sa / sb;
         end
         4'd12: return (b == 0) ? ONES : a / b;
         4'd13: begin
            if (b == 0) return a;
            if (a == MIN && b == ONES) return 64'd0;
            return sa % sb;
         end
         4'd14: return (b == 0) ? a : a % b;
         default: return 64'd0;
      endcase
   endfunction

   function automatic logic [63:0] rnd_val();
      case ($urandom_range(0, 6))
         0: return 64'd0;
         1: return ONES;
         2: return MIN;
         3: return 64'($urandom_range(0, 20));
         4: return -64'($urandom_range(1, 20));
         default: return {$urandom, $urandom};
      endcase
   endfunction

   // One op from IDLE through result and drain, with 'hold' cycles of
   // back-pressure once the result shows up.
   task automatic run_op(input string tag, input logic [3:0] op, input logic [63:0] a,
                         input logic [63:0] b, input logic eb, input logic inv,
                         input int hold, output logic [63:0] got);
      logic [63:0] j1, j2, exp_rd;
      int          lat;
      bit          rdy_busy;
      j1     = {$urandom, $urandom};
      j2     = {$urandom, $urandom};
      exp_rd = ref_rd(op, a, b, inv);
      @(negedge clk);
      in_op = op; in_op1 = a; in_op2 = b; in_j1 = j1; in_j2 = j2;
      in_ebreak = eb; in_invalid = inv; in_valid = 1'b1; out_ready = 1'b0;
      #1;
      check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_op1 = {$urandom, $urandom}; in_op2 = {$urandom, $urandom};
      in_j1 = {$urandom, $urandom};  in_j2 = {$urandom, $urandom};
      in_ebreak = ~eb; in_invalid = ~inv;
      lat = 0;
      rdy_busy = 1'b0;
      while (1) begin
         @(negedge clk);
         lat++;
         if (out_valid || lat >= 200) break;
         if (in_ready) rdy_busy = 1'b1;
      end
      got = out_rd_data;
      check({tag, "_latency"}, 64'(lat), 64'(ref_lat(op, inv)));
      check({tag, "_rd"}, out_rd_data, exp_rd);
      check({tag, "_jump"}, out_jump_addr, j1 + j2);
      check({tag, "_ebreak"}, 64'(out_ebreak), 64'(eb));
      check({tag, "_invalid"}, 64'(out_invalid), 64'(ref_inv(op, inv)));
      check({tag, "_ready_while_busy"}, 64'(rdy_busy), 64'd0);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
         check({tag, "_hold_rd"}, out_rd_data, exp_rd);
         check({tag, "_hold_in_ready"}, 64'(in_ready), 64'd0);
      end
      out_ready = 1'b1;
      #1;
      check({tag, "_release_ready"}, 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      @(negedge clk);
      check({tag, "_drained"}, 64'(out_valid), 64'd0);
   endtask

   // Watches for any out_valid over n cycles.
   task automatic watch_quiet(input string tag, input int n);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      check(tag, 64'(seen), 64'd0);
   endtask

   initial begin
      #10_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] got;
      logic [3:0]  rop;
      logic [63:0] ra, rb;

      // Reset state, with an op offered while rst is high.
      repeat (2) @(posedge clk);
      @(negedge clk);
      in_valid = 1'b1;
      #1;
      check("rst_in_ready", 64'(in_ready), 64'd0);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_rd", out_rd_data, 64'd0);
      check("rst_jump", out_jump_addr, 64'd0);
      check("rst_ebreak", 64'(out_ebreak), 64'd0);
      check("rst_invalid", 64'(out_invalid), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      check("post_rst_valid", 64'(out_valid), 64'd0);

      // Back-to-back ADD then XOR with out_ready high.
      @(negedge clk);
      in_op = 4'd0; in_op1 = ONES; in_op2 = 64'd2; in_j1 = 64'd100; in_j2 = 64'd4;
      in_ebreak = 1'b0; in_invalid = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk);
      #1;
      in_op = 4'd4; in_op1 = 64'd5; in_op2 = 64'd7;
      @(negedge clk);
      check("b2b_valid0", 64'(out_valid), 64'd1);
      check("b2b_rd0", out_rd_data, 64'd1);
      check("b2b_jump0", out_jump_addr, 64'd104);
      check("b2b_in_ready", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      check("b2b_valid1", 64'(out_valid), 64'd1);
      check("b2b_rd1", out_rd_data, 64'd2);
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      @(negedge clk);
      check("b2b_drained", 64'(out_valid), 64'd0);

      // Directed ops against literal results.
      run_op("sra", 4'd7, MIN, 64'h41, 1'b0, 1'b0, 0, got);
      check("sra_lit", got, 64'hC000_0000_0000_0000);
      run_op("sltu", 4'd9, 64'd1, ONES, 1'b0, 1'b0, 0, got);
      check("sltu_lit", got, 64'd1);
      run_op("slt", 4'd8, 64'd1, ONES, 1'b0, 1'b0, 0, got);
      check("slt_lit", got, 64'd0);
      run_op("mul", 4'd10, 64'h1_0000_0001, 64'd3, 1'b0, 1'b0, 0, got);
      check("mul_lit", got, MD_EN ? 64'h3_0000_0003 : 64'd0);
      run_op("div", 4'd11, -64'd7, 64'd2, 1'b0, 1'b0, 5, got);
      check("div_lit", got, MD_EN ? -64'd3 : 64'd0);
      run_op("rem", 4'd13, -64'd7, 64'd2, 1'b0, 1'b0, 0, got);
      check("rem_lit", got, MD_EN ? ONES : 64'd0);
      run_op("divu0", 4'd12, 64'd7, 64'd0, 1'b0, 1'b0, 0, got);
      check("divu0_lit", got, MD_EN ? ONES : 64'd0);
      run_op("rem0", 4'd13, 64'd7, 64'd0, 1'b0, 1'b0, 0, got);
      check("rem0_lit", got, MD_EN ? 64'd7 : 64'd0);
      run_op("div_ovf", 4'd11, MIN, ONES, 1'b0, 1'b0, 0, got);
      check("div_ovf_lit", got, MD_EN ? MIN : 64'd0);
      run_op("rem_ovf", 4'd13, MIN, ONES, 1'b0, 1'b0, 0, got);
      check("rem_ovf_lit", got, 64'd0);
      run_op("rsvd", 4'd15, 64'd9, 64'd9, 1'b0, 1'b0, 0, got);
      run_op("illegal", 4'd0, 64'd9, 64'd9, 1'b0, 1'b1, 0, got);
      run_op("ebreak_div", 4'd12, 64'd100, 64'd7, 1'b1, 1'b0, 1, got);

      // Result held under back-pressure; the waiting op enters the same cycle
      // out_ready rises.
      @(negedge clk);
      in_op = 4'd0; in_op1 = 64'd10; in_op2 = 64'd20; in_valid = 1'b1; out_ready = 1'b0;
      in_ebreak = 1'b0; in_invalid = 1'b0;
      @(posedge clk);
      #1;
      in_op = 4'd1; in_op1 = 64'd50; in_op2 = 64'd8;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_valid", 64'(out_valid), 64'd1);
         check("bp_rd", out_rd_data, 64'd30);
         check("bp_in_ready", 64'(in_ready), 64'd0);
      end
      out_ready = 1'b1;
      #1;
      check("bp_release_ready", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      check("bp_next_valid", 64'(out_valid), 64'd1);
      check("bp_next_rd", out_rd_data, 64'd42);
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      @(negedge clk);
      check("bp_drained", 64'(out_valid), 64'd0);

      // Flush in the middle of a DIV.
      @(negedge clk);
      in_op = 4'd11; in_op1 = 64'd1000; in_op2 = 64'd7; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (20) @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      @(negedge clk);
      check("flush_in_ready", 64'(in_ready), 64'd1);
      check("flush_valid", 64'(out_valid), 64'd0);
      watch_quiet("flush_no_result", 80);

      // Flush drops a held ALU result.
      @(negedge clk);
      in_op = 4'd0; in_op1 = 64'd1; in_op2 = 64'd1; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      check("flush_held_pre", 64'(out_valid), 64'd1);
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      @(negedge clk);
      check("flush_held_post", 64'(out_valid), 64'd0);

      // Flush together with in_valid: op must not be taken.
      flush = 1'b1; in_valid = 1'b1; in_op = 4'd0;
      #1;
      check("flush_accept_ready", 64'(in_ready), 64'd0);
      @(posedge clk);
      #1;
      flush = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      check("flush_accept_none", 64'(out_valid), 64'd0);

      // Reset in the middle of a MUL.
      @(negedge clk);
      in_op = 4'd10; in_op1 = 64'd12345; in_op2 = 64'd678; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (10) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("midrst_in_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
      check("midrst_valid", 64'(out_valid), 64'd0);
      check("midrst_rd", out_rd_data, 64'd0);
      rst = 1'b0;
      watch_quiet("midrst_no_result", 80);
      out_ready = 1'b0;

      // Randomized ops against the reference model.
      for (int n = 0; n < 60; n++) begin
         rop = 4'($urandom_range(0, 15));
         ra  = rnd_val();
         rb  = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 80)) : rnd_val();
         run_op($sformatf("rnd%0d_op%0d", n, rop), rop, ra, rb, 1'($urandom_range(0, 1)),
                ($urandom_range(0, 7) == 0), $urandom_range(0, 2), got);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
